// File: rtl/gpr_sched_pkg_ysyx_23060136.sv
// Purpose: shared types and constants for the RV32E GPR writeback scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a. Exports NUM_GPR, XLEN, wb_grant_t, gpr_idx_t, popcount16().
package gpr_sched_pkg_ysyx_23060136;

  localparam int NUM_GPR = 16;
  localparam int XLEN    = 32;

  typedef enum logic {GNT_EXU, GNT_LSU} wb_grant_t;

  typedef logic [4:0] gpr_idx_t;

  // Number of set bits in a 16-bit register mask (0..16 fits in 5 bits).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gpr_wb_sched_ysyx_23060136_rr_arb2.sv
// Purpose: two-requester round-robin arbiter (EXU / LSU) with last-grant memory.
// Latency: grant is combinational from req; last_grant updates at the granting edge.
// Backpressure: a losing requester keeps req high until granted. Ports: clk, rst (async low), req_exu, req_lsu, gnt[1:0] (bit0 EXU, bit1 LSU).
module rr_arb2_ysyx_23060136
  import gpr_sched_pkg_ysyx_23060136::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_exu,
  input  logic       req_lsu,
  output logic [1:0] gnt
);

  wb_grant_t last_grant_q, last_grant_d;

  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    if (req_exu && req_lsu) begin
      // Conflict: favour whoever did not win last time.
      if (last_grant_q == GNT_EXU) gnt = 2'b10;
      else                         gnt = 2'b01;
    end else if (req_exu) begin
      gnt = 2'b01;
    end else if (req_lsu) begin
      gnt = 2'b10;
    end
    if (gnt[1])      last_grant_d = GNT_LSU;
    else if (gnt[0]) last_grant_d = GNT_EXU;
  end

  // Reset to EXU so that LSU wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= GNT_EXU;
    else      last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/gpr_wb_sched_ysyx_23060136.sv
// Purpose: GPR busy scoreboard (RAW/WAW issue stall) plus single write-port scheduler for EXU/LSU writeback.
// Latency: grant in cycle N -> RegWr/WBU_rd/rf_busW in N+1 -> busy clear at end of N+1; dependent issue ready in N+2.
// Backpressure: issue_ready drops on hazard; exu/lsu_wb_ready is the combinational grant. Outputs: RegWr/WBU_rd/rf_busW, outstanding, wb_err.
module gpr_wb_sched_ysyx_23060136
  import gpr_sched_pkg_ysyx_23060136::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wen,
  output logic            issue_ready,
  input  logic            exu_wb_valid,
  input  logic [4:0]      exu_wb_rd,
  input  logic [XLEN-1:0] exu_wb_data,
  output logic            exu_wb_ready,
  input  logic            lsu_wb_valid,
  input  logic [4:0]      lsu_wb_rd,
  input  logic [XLEN-1:0] lsu_wb_data,
  output logic            lsu_wb_ready,
  output logic            RegWr,
  output logic [4:0]      WBU_rd,
  output logic [XLEN-1:0] rf_busW,
  output logic [4:0]      outstanding,
  output logic            wb_err
);

  logic [NUM_GPR-1:0] busy_q, busy_d;
  logic [4:0]         outstanding_q, outstanding_d;
  logic               reg_wr_q, reg_wr_d;
  gpr_idx_t           wbu_rd_q, wbu_rd_d;
  logic [XLEN-1:0]    bus_w_q, bus_w_d;
  logic               wb_err_q, wb_err_d;

  logic [1:0]      gnt;
  logic            wb_fire;
  gpr_idx_t        wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [3:0]      rs1_idx, rs2_idx, rd_idx, wb_idx;
  logic            hz, issue_fire;

  // Only the low four index bits address the RV32E file.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{issue_rs1[4], issue_rs2[4], issue_rd[4]};

  assign rs1_idx = issue_rs1[3:0];
  assign rs2_idx = issue_rs2[3:0];
  assign rd_idx  = issue_rd[3:0];

  rr_arb2_ysyx_23060136 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_exu (exu_wb_valid),
    .req_lsu (lsu_wb_valid),
    .gnt     (gnt)
  );

  assign exu_wb_ready = gnt[0];
  assign lsu_wb_ready = gnt[1];
  assign wb_fire      = gnt[0] | gnt[1];
  assign wb_rd        = gnt[1] ? lsu_wb_rd   : exu_wb_rd;
  assign wb_data      = gnt[1] ? lsu_wb_data : exu_wb_data;
  assign wb_idx       = wb_rd[3:0];

  assign hz = ((rs1_idx != 4'd0) && busy_q[rs1_idx]) ||
              ((rs2_idx != 4'd0) && busy_q[rs2_idx]) ||
              (issue_wen && (rd_idx != 4'd0) && busy_q[rd_idx]);
  assign issue_ready = ~hz;
  assign issue_fire  = issue_valid & issue_ready;

  always_comb begin
    busy_d   = busy_q;
    reg_wr_d = 1'b0;
    wbu_rd_d = wbu_rd_q;
    bus_w_d  = bus_w_q;
    wb_err_d = wb_err_q;

    // Clear at the edge where the file captures the data; the WAW check
    // guarantees this never collides with a set on the same index.
    if (reg_wr_q) busy_d[wbu_rd_q[3:0]] = 1'b0;
    if (issue_fire && issue_wen && (rd_idx != 4'd0)) busy_d[rd_idx] = 1'b1;
    busy_d[0] = 1'b0;

    if (wb_fire) begin
      reg_wr_d = (wb_idx != 4'd0);
      wbu_rd_d = wb_rd;
      bus_w_d  = wb_data;
      if ((wb_idx != 4'd0) && !busy_q[wb_idx]) wb_err_d = 1'b1;
    end

    outstanding_d = popcount16(busy_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      reg_wr_q      <= 1'b0;
      wbu_rd_q      <= '0;
      bus_w_q       <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      reg_wr_q      <= reg_wr_d;
      wbu_rd_q      <= wbu_rd_d;
      bus_w_q       <= bus_w_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign RegWr       = reg_wr_q;
  assign WBU_rd      = wbu_rd_q;
  assign rf_busW     = bus_w_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_gpr_wb_sched_ysyx_23060136.sv
// Purpose: directed bench for the GPR writeback scheduler; write-port traffic checked by a scoreboard monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_gpr_wb_sched_ysyx_23060136;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_wen;
  logic        issue_ready;
  logic        exu_wb_valid;
  logic [4:0]  exu_wb_rd;
  logic [31:0] exu_wb_data;
  logic        exu_wb_ready;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        lsu_wb_ready;
  logic        RegWr;
  logic [4:0]  WBU_rd;
  logic [31:0] rf_busW;
  logic [4:0]  outstanding;
  logic        wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected write-port beats: {rd, data}, in expected grant order.
  logic [36:0] exp_q[$];

  gpr_wb_sched_ysyx_23060136 dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .issue_wen    (issue_wen),
    .issue_ready  (issue_ready),
    .exu_wb_valid (exu_wb_valid),
    .exu_wb_rd    (exu_wb_rd),
    .exu_wb_data  (exu_wb_data),
    .exu_wb_ready (exu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .RegWr        (RegWr),
    .WBU_rd       (WBU_rd),
    .rf_busW      (rf_busW),
    .outstanding  (outstanding),
    .wb_err       (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write-port beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1 && RegWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got rd %0d data %0h, want no write", WBU_rd, rf_busW);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, WBU_rd}, {27'd0, e[36:32]});
        chk("wb_data", rf_busW, e[31:0]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wen);
    issue_valid = v;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
    issue_wen   = wen;
  endtask

  task automatic set_exu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    exu_wb_valid = v;
    exu_wb_rd    = rd;
    exu_wb_data  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_wb_valid = v;
    lsu_wb_rd    = rd;
    lsu_wb_data  = d;
  endtask

  initial begin
    rst = 1'b0;
    set_issue(0, 0, 0, 0, 0);
    set_exu(0, 0, 0);
    set_lsu(0, 0, 0);
    #3;
    chk("rst_regwr", {31'd0, RegWr}, 32'd0);
    chk("rst_wbu_rd", {27'd0, WBU_rd}, 32'd0);
    chk("rst_busw", rf_busW, 32'd0);
    chk("rst_outstanding", {27'd0, outstanding}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    tick;
    tick;
    rst = 1'b1;

    // RAW on x5 resolved by an EXU writeback.
    set_issue(1, 0, 0, 5, 1);
    @(negedge clk); chk("s1_issue_rd5_ready", {31'd0, issue_ready}, 32'd1);
    tick;
    set_issue(1, 5, 0, 0, 0);
    @(negedge clk);
    chk("s1_outstanding1", {27'd0, outstanding}, 32'd1);
    chk("s1_raw_stall", {31'd0, issue_ready}, 32'd0);
    tick;
    set_exu(1, 5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);
    chk("s1_exu_ready", {31'd0, exu_wb_ready}, 32'd1);
    tick;
    set_exu(0, 0, 0);
    @(negedge clk); chk("s1_stall_in_n1", {31'd0, issue_ready}, 32'd0);
    tick;
    @(negedge clk);
    chk("s1_ready_n2", {31'd0, issue_ready}, 32'd1);
    chk("s1_outstanding0", {27'd0, outstanding}, 32'd0);
    tick;

    // Conflicting writebacks: LSU first, then round-robin to EXU, then LSU again.
    set_issue(1, 0, 0, 3, 1); tick;
    set_issue(1, 0, 0, 7, 1); tick;
    set_issue(1, 0, 0, 8, 1); tick;
    set_issue(0, 0, 0, 0, 0);
    set_exu(1, 3, 32'h33333333);
    set_lsu(1, 7, 32'h77777777);
    exp_q.push_back({5'd7, 32'h77777777});
    exp_q.push_back({5'd3, 32'h33333333});
    exp_q.push_back({5'd8, 32'h88888888});
    @(negedge clk);
    chk("s2_outstanding3", {27'd0, outstanding}, 32'd3);
    chk("s2_c1_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
    chk("s2_c1_exu_ready", {31'd0, exu_wb_ready}, 32'd0);
    tick;
    set_lsu(1, 8, 32'h88888888);
    @(negedge clk);
    chk("s2_c2_exu_ready", {31'd0, exu_wb_ready}, 32'd1);
    chk("s2_c2_lsu_ready", {31'd0, lsu_wb_ready}, 32'd0);
    tick;
    set_exu(0, 0, 0);
    @(negedge clk); chk("s2_c3_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
    tick;
    set_lsu(0, 0, 0);
    tick;
    @(negedge clk); chk("s2_outstanding0", {27'd0, outstanding}, 32'd0);

    // Issue to x0 leaves the scoreboard untouched; x0 reads never stall.
    tick;
    set_issue(1, 0, 0, 0, 1);
    @(negedge clk); chk("s3_rd0_ready", {31'd0, issue_ready}, 32'd1);
    tick;
    set_issue(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("s3_outstanding0", {27'd0, outstanding}, 32'd0);
    chk("s3_rs0_ready", {31'd0, issue_ready}, 32'd1);
    tick;

    // WAW on x4.
    set_issue(1, 0, 0, 4, 1); tick;
    @(negedge clk); chk("s4_waw_stall", {31'd0, issue_ready}, 32'd0);
    set_issue(1, 0, 0, 4, 0);
    #1; chk("s4_nowen_ready", {31'd0, issue_ready}, 32'd1);
    tick;
    set_issue(1, 0, 0, 4, 1);
    set_exu(1, 4, 32'h44444444);
    exp_q.push_back({5'd4, 32'h44444444});
    @(negedge clk); chk("s4_waw_stall_n", {31'd0, issue_ready}, 32'd0);
    tick;
    set_exu(0, 0, 0);
    @(negedge clk); chk("s4_waw_stall_n1", {31'd0, issue_ready}, 32'd0);
    tick;
    @(negedge clk); chk("s4_waw_ready_n2", {31'd0, issue_ready}, 32'd1);
    tick;
    set_issue(0, 0, 0, 0, 0);
    set_exu(1, 4, 32'h4444AAAA);
    exp_q.push_back({5'd4, 32'h4444AAAA});
    tick;
    set_exu(0, 0, 0);
    tick;
    @(negedge clk);
    chk("s4_outstanding0", {27'd0, outstanding}, 32'd0);
    chk("s4_no_err", {31'd0, wb_err}, 32'd0);
    tick;

    // Writeback to a non-busy register flags a sticky error.
    set_lsu(1, 9, 32'h99990009);
    exp_q.push_back({5'd9, 32'h99990009});
    @(negedge clk); chk("s5_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
    tick;
    set_lsu(0, 0, 0);
    @(negedge clk); chk("s5_err_set", {31'd0, wb_err}, 32'd1);
    tick; tick; tick;
    @(negedge clk); chk("s5_err_sticky", {31'd0, wb_err}, 32'd1);
    tick;

    // Fill the scoreboard, then reset in the middle of an in-flight write.
    for (int i = 1; i < 16; i++) begin
      set_issue(1, 0, 0, 5'(i), 1);
      tick;
    end
    set_issue(1, 5, 0, 6, 1);
    @(negedge clk);
    chk("s6_outstanding15", {27'd0, outstanding}, 32'd15);
    chk("s6_full_stall", {31'd0, issue_ready}, 32'd0);
    tick;
    set_exu(1, 2, 32'h22222222);
    exp_q.push_back({5'd2, 32'h22222222});
    tick;
    set_exu(0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s6_rst_regwr", {31'd0, RegWr}, 32'd0);
    chk("s6_rst_wbu_rd", {27'd0, WBU_rd}, 32'd0);
    chk("s6_rst_busw", rf_busW, 32'd0);
    chk("s6_rst_outstanding", {27'd0, outstanding}, 32'd0);
    chk("s6_rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("s6_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    set_issue(0, 0, 0, 0, 0);
    tick;
    rst = 1'b1;
    tick;
    @(negedge clk);
    chk("s6_post_outstanding", {27'd0, outstanding}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
